// File: rtl/clock_pkg.sv
// Encodings shared between the front-panel controller and the DigitalClock core.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'd0,
        MODE_TIMER = 2'd1,
        MODE_ALARM = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        SELECT_NONE = 2'd0,
        SELECT_SEC  = 2'd1,
        SELECT_MIN  = 2'd2,
        SELECT_HOUR = 2'd3
    } select_t;

    localparam int unsigned RING_SRC_TIMER = 0;

    // Bit positions of the five buttons in the panel's internal press vector.
    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;
    localparam int N_BTN = 5;

    function automatic select_t next_select(input select_t s);
        return select_t'(s + 2'd1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: level follows raw after CYCLES stable samples; press marks a 0->1 flip.
// raw is expected to be already synchronised to clk.
module btn_debounce #(
    parameter int unsigned CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (raw == level) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                cnt   <= '0;
                level <= raw;
                press <= raw;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/panel_ctrl.sv
// Front-panel controller: button debounce, mode/field FSM, alarm/timer enables and beeping ring tone.
module panel_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned     N_ALARMS            = 2,
    parameter int unsigned     DEBOUNCE_CYCLES     = 1_000_000,
    parameter int unsigned     TONE_HALF_CYCLES    = 33_333,
    parameter int unsigned     BEEP_ON_CYCLES      = 25_000_000,
    parameter int unsigned     BEEP_OFF_CYCLES     = 25_000_000,
    parameter longint unsigned RING_TIMEOUT_CYCLES = 64'd6_000_000_000,
    localparam int unsigned    IDX_W               = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1,
    localparam int unsigned    SRC_W               = $clog2(N_ALARMS + 1)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                btn_c,
    input  logic                btn_u,
    input  logic                btn_l,
    input  logic                btn_r,
    input  logic                btn_d,
    input  logic [N_ALARMS-1:0] alarm_hit,
    input  logic                timer_hit,
    output logic [1:0]          mode,
    output logic [IDX_W-1:0]    alarm_idx,
    output logic [1:0]          select,
    output logic                increment,
    output logic                timer_enable,
    output logic [N_ALARMS-1:0] alarm_enable,
    output logic                ringing,
    output logic [SRC_W-1:0]    ring_src,
    output logic                aud_pwm
);

    localparam int unsigned PHASE_MAX = (BEEP_ON_CYCLES > BEEP_OFF_CYCLES) ? BEEP_ON_CYCLES : BEEP_OFF_CYCLES;
    localparam int unsigned PW        = $clog2(PHASE_MAX + 1);
    localparam int unsigned TW        = $clog2(TONE_HALF_CYCLES + 1);

    logic [N_BTN-1:0] raw_btn, btn_press, unused_level;

    assign raw_btn = {btn_d, btn_r, btn_l, btn_u, btn_c};

    for (genvar b = 0; b < N_BTN; b++) begin : g_btn
        btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .resetn(resetn),
            .raw   (raw_btn[b]),
            .level (unused_level[b]),
            .press (btn_press[b])
        );
    end

    mode_t                mode_q, mode_n;
    select_t              sel_q, sel_n;
    logic [IDX_W-1:0]     idx_q, idx_n, arb_idx;
    logic [SRC_W-1:0]     src_q, src_n, arb_src;
    logic                 te_q, te_n, ring_q, ring_n, inc_q, inc_n;
    logic [N_ALARMS-1:0]  ae_q, ae_n, alarm_hit_q, alarm_rise;
    logic                 timer_hit_q, timer_rise, hit_start;
    logic                 on_q, on_n, tone_q, tone_n;
    logic [PW-1:0]        ph_q, ph_n;
    logic [TW-1:0]        tc_q, tc_n;
    logic [63:0]          to_q, to_n;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q      <= MODE_CLOCK;
            sel_q       <= SELECT_NONE;
            idx_q       <= '0;
            src_q       <= '0;
            te_q        <= 1'b0;
            ae_q        <= '0;
            ring_q      <= 1'b0;
            inc_q       <= 1'b0;
            on_q        <= 1'b0;
            tone_q      <= 1'b0;
            ph_q        <= '0;
            tc_q        <= '0;
            to_q        <= '0;
            timer_hit_q <= 1'b0;
            alarm_hit_q <= '0;
        end else begin
            mode_q      <= mode_n;
            sel_q       <= sel_n;
            idx_q       <= idx_n;
            src_q       <= src_n;
            te_q        <= te_n;
            ae_q        <= ae_n;
            ring_q      <= ring_n;
            inc_q       <= inc_n;
            on_q        <= on_n;
            tone_q      <= tone_n;
            ph_q        <= ph_n;
            tc_q        <= tc_n;
            to_q        <= to_n;
            timer_hit_q <= timer_hit;
            alarm_hit_q <= alarm_hit;
        end
    end

    assign timer_rise = timer_hit & ~timer_hit_q;
    assign alarm_rise = alarm_hit & ~alarm_hit_q & ae_q;
    assign hit_start  = !ring_q && (timer_rise || (|alarm_rise));

    // Lowest enabled alarm index with a rising edge wins; the timer outranks all alarms below.
    always_comb begin
        arb_src = '0;
        arb_idx = '0;
        for (int k = int'(N_ALARMS) - 1; k >= 0; k--) begin
            if (alarm_rise[k]) begin
                arb_src = SRC_W'(k + 1);
                arb_idx = IDX_W'(k);
            end
        end
    end

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    always_comb begin
        mode_n = mode_q;
        sel_n  = sel_q;
        idx_n  = idx_q;
        src_n  = src_q;
        te_n   = te_q;
        ae_n   = ae_q;
        ring_n = ring_q;
        inc_n  = 1'b0;
        on_n   = on_q;
        tone_n = tone_q;
        ph_n   = ph_q;
        tc_n   = tc_q;
        to_n   = to_q;

        if (hit_start) begin
            ring_n = 1'b1;
            sel_n  = SELECT_NONE;
            to_n   = '0;
            on_n   = 1'b1;
            ph_n   = '0;
            tc_n   = '0;
            tone_n = 1'b0;
            if (timer_rise) begin
                src_n  = SRC_W'(RING_SRC_TIMER);
                mode_n = MODE_TIMER;
                te_n   = 1'b0;
            end else begin
                src_n  = arb_src;
                mode_n = MODE_ALARM;
                idx_n  = arb_idx;
            end
        end else if (ring_q) begin
            // Any press while ringing is an acknowledge only.
            if ((|btn_press) || (to_q == 64'(RING_TIMEOUT_CYCLES - 1)))
                ring_n = 1'b0;
            to_n = to_q + 64'd1;
            if (on_q) begin
                if (ph_q == PW'(BEEP_ON_CYCLES - 1)) begin
                    on_n   = 1'b0;
                    ph_n   = '0;
                    tc_n   = '0;
                    tone_n = 1'b0;
                end else begin
                    ph_n = ph_q + 1'b1;
                    if (tc_q == TW'(TONE_HALF_CYCLES - 1)) begin
                        tc_n   = '0;
                        tone_n = !tone_q;
                    end else begin
                        tc_n = tc_q + 1'b1;
                    end
                end
            end else if (ph_q == PW'(BEEP_OFF_CYCLES - 1)) begin
                on_n   = 1'b1;
                ph_n   = '0;
                tc_n   = '0;
                tone_n = 1'b0;
            end else begin
                ph_n = ph_q + 1'b1;
            end
        end else begin
            inc_n = btn_press[BTN_U];
            if (btn_press[BTN_D])
                sel_n = next_select(sel_q);
            if (btn_press[BTN_R]) begin
                case (mode_q)
                    MODE_CLOCK: begin
                        mode_n = MODE_TIMER;
                        sel_n  = SELECT_SEC;
                    end
                    MODE_TIMER: begin
                        mode_n = MODE_ALARM;
                        idx_n  = '0;
                        sel_n  = SELECT_SEC;
                    end
                    default: begin
                        if (idx_q == IDX_W'(N_ALARMS - 1)) begin
                            mode_n = MODE_CLOCK;
                            idx_n  = '0;
                            sel_n  = SELECT_NONE;
                        end else begin
                            idx_n = idx_q + 1'b1;
                            sel_n = SELECT_SEC;
                        end
                    end
                endcase
            end
            if (btn_press[BTN_C] && (mode_q == MODE_TIMER))
                te_n = !te_q;
            if (btn_press[BTN_L] && (mode_q == MODE_ALARM))
                ae_n[idx_q] = !ae_q[idx_q];
        end
    end

    always_comb begin
        mode         = mode_q;
        alarm_idx    = idx_q;
        select       = sel_q;
        increment    = inc_q;
        timer_enable = te_q;
        alarm_enable = ae_q;
        ringing      = ring_q;
        ring_src     = src_q;
        aud_pwm      = ring_q & on_q & tone_q;
    end

endmodule

// File: tb/tb_panel_ctrl.sv
// Self-checking bench for panel_ctrl: state scoreboard on every press/hit plus a per-cycle tone scoreboard.
`timescale 1ns/1ps
module tb_panel_ctrl;
    import clock_pkg::*;

    localparam int DEB  = 4;
    localparam int HALF = 3;
    localparam int ON   = 12;
    localparam int OFF  = 6;
    localparam int TMO  = 100;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [4:0] btn = '0;
    logic [2:0] alarm_hit = '0;
    logic       timer_hit = 1'b0;
    logic [1:0] mode, alarm_idx, select, ring_src;
    logic       increment, timer_enable, ringing, aud_pwm;
    logic [2:0] alarm_enable;

    always #5 clk = ~clk;

    panel_ctrl #(
        .N_ALARMS           (3),
        .DEBOUNCE_CYCLES    (DEB),
        .TONE_HALF_CYCLES   (HALF),
        .BEEP_ON_CYCLES     (ON),
        .BEEP_OFF_CYCLES    (OFF),
        .RING_TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .btn_c       (btn[BTN_C]),
        .btn_u       (btn[BTN_U]),
        .btn_l       (btn[BTN_L]),
        .btn_r       (btn[BTN_R]),
        .btn_d       (btn[BTN_D]),
        .alarm_hit   (alarm_hit),
        .timer_hit   (timer_hit),
        .mode        (mode),
        .alarm_idx   (alarm_idx),
        .select      (select),
        .increment   (increment),
        .timer_enable(timer_enable),
        .alarm_enable(alarm_enable),
        .ringing     (ringing),
        .ring_src    (ring_src),
        .aud_pwm     (aud_pwm)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [1:0] idx;
        logic [1:0] sel;
        logic [1:0] src;
        logic       te;
        logic       ring;
        logic [2:0] ae;
        int         inc;
    } st_t;

    st_t  m;
    st_t  sb_q[$];
    logic tone_sb[$];
    int   inc_seen = 0;
    logic prev_t = 1'b0;
    logic [2:0] prev_a = '0;

    always @(negedge clk) if (increment === 1'b1) inc_seen++;
    always @(negedge clk) if (tone_sb.size() > 0) check("aud_pwm", aud_pwm, tone_sb.pop_front());

    function automatic void model_reset();
        m.mode = MODE_CLOCK; m.idx = '0; m.sel = SELECT_NONE; m.src = '0;
        m.te = 1'b0; m.ring = 1'b0; m.ae = '0;
    endfunction

    function automatic void model_press(input int b);
        if (m.ring) begin
            m.ring = 1'b0;
            return;
        end
        case (b)
            BTN_C: if (m.mode == MODE_TIMER) m.te = ~m.te;
            BTN_U: m.inc++;
            BTN_L: if (m.mode == MODE_ALARM) m.ae[m.idx] = ~m.ae[m.idx];
            BTN_R: begin
                if (m.mode == MODE_CLOCK) begin
                    m.mode = MODE_TIMER; m.sel = SELECT_SEC;
                end else if (m.mode == MODE_TIMER) begin
                    m.mode = MODE_ALARM; m.idx = 2'd0; m.sel = SELECT_SEC;
                end else if (m.idx < 2'd2) begin
                    m.idx = m.idx + 2'd1; m.sel = SELECT_SEC;
                end else begin
                    m.mode = MODE_CLOCK; m.idx = 2'd0; m.sel = SELECT_NONE;
                end
            end
            default: m.sel = m.sel + 2'd1;
        endcase
    endfunction

    function automatic logic tone_at(input int j);
        int p;
        if (j >= TMO) return 1'b0;
        p = j % (ON + OFF);
        if (p >= ON) return 1'b0;
        return ((p / HALF) % 2) == 1;
    endfunction

    task automatic sb_compare(input string tag);
        st_t e;
        check({tag, ".sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, ".mode"}, mode, e.mode);
            check({tag, ".alarm_idx"}, alarm_idx, e.idx);
            check({tag, ".select"}, select, e.sel);
            check({tag, ".timer_enable"}, timer_enable, e.te);
            check({tag, ".alarm_enable"}, alarm_enable, e.ae);
            check({tag, ".ringing"}, ringing, e.ring);
            check({tag, ".ring_src"}, ring_src, e.src);
            check({tag, ".increments"}, inc_seen, e.inc);
            check({tag, ".increment"}, increment, 1'b0);
        end
    endtask

    // Full press: hold long enough to be accepted, release long enough to settle, then compare.
    task automatic press(input int b, input string tag);
        model_press(b);
        sb_q.push_back(m);
        btn[b] = 1'b1;
        repeat (DEB + 1) @(posedge clk);
        #1;
        btn[b] = 1'b0;
        repeat (DEB + 1) @(posedge clk);
        #1;
        sb_compare(tag);
    endtask

    task automatic hit(input logic t, input logic [2:0] a, input string tag, input bit track_tone);
        logic [2:0] rise_a;
        rise_a = a & ~prev_a & m.ae;
        if (!m.ring && ((t && !prev_t) || (rise_a != 3'b000))) begin
            m.ring = 1'b1;
            m.sel  = SELECT_NONE;
            if (t && !prev_t) begin
                m.src = 2'd0; m.mode = MODE_TIMER; m.te = 1'b0;
            end else begin
                m.mode = MODE_ALARM;
                if (rise_a[0])      begin m.src = 2'd1; m.idx = 2'd0; end
                else if (rise_a[1]) begin m.src = 2'd2; m.idx = 2'd1; end
                else                begin m.src = 2'd3; m.idx = 2'd2; end
            end
        end
        timer_hit = t;
        alarm_hit = a;
        prev_t    = t;
        prev_a    = a;
        @(posedge clk);
        sb_q.push_back(m);
        if (track_tone)
            for (int j = 0; j < TMO + 5; j++) tone_sb.push_back(tone_at(j));
        #1;
        sb_compare(tag);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        m.inc = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        sb_q.push_back(m);
        sb_compare("reset");
        check("reset.aud_pwm", aud_pwm, 1'b0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Bounce 1-0-1, then hold: one press, accepted DEB+1 edges after the stable level starts.
        btn[BTN_R] = 1'b1; @(posedge clk); #1;
        btn[BTN_R] = 1'b0; @(posedge clk); #1;
        btn[BTN_R] = 1'b1;
        repeat (DEB) @(posedge clk);
        #1;
        check("bounce.mode_early", mode, MODE_CLOCK);
        @(posedge clk);
        #1;
        check("bounce.mode_on_time", mode, MODE_TIMER);
        check("bounce.select_on_time", select, SELECT_SEC);
        model_press(BTN_R);
        sb_q.push_back(m);
        @(posedge clk);
        #1;
        btn[BTN_R] = 1'b0;
        repeat (DEB + 1) @(posedge clk);
        #1;
        sb_compare("bounce");

        press(BTN_R, "r_alarm0");
        press(BTN_R, "r_alarm1");
        press(BTN_R, "r_alarm2");
        press(BTN_R, "r_clock");
        press(BTN_C, "c_in_clock");
        press(BTN_L, "l_in_clock");
        press(BTN_D, "d_sec");
        press(BTN_D, "d_min");
        press(BTN_D, "d_hour");
        press(BTN_D, "d_none");
        press(BTN_R, "r_timer");
        press(BTN_C, "c_timer_en");
        press(BTN_R, "r_alarm0_b");
        press(BTN_R, "r_alarm1_b");
        press(BTN_L, "l_alarm1_en");

        // Channel 0 is disabled, so channel 1 is the source.
        hit(1'b0, 3'b011, "alarm_ring", 1'b0);
        press(BTN_U, "ack");
        press(BTN_U, "inc_after_ack");
        hit(1'b0, 3'b000, "alarm_low", 1'b0);

        press(BTN_R, "r_alarm2_b");
        press(BTN_R, "r_clock_b");
        press(BTN_R, "r_timer_b");

        // Timer beats alarm 1; tone cadence tracked per cycle; new alarm edge mid-ring ignored.
        hit(1'b1, 3'b010, "timer_ring", 1'b1);
        n = 0;
        while (ringing === 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 20) begin alarm_hit = 3'b000; prev_a = 3'b000; end
            if (n == 25) begin alarm_hit = 3'b010; prev_a = 3'b010; end
            if (n == 40) check("ring_src_hold", ring_src, 2'd0);
        end
        check("timeout_cycles", n, TMO);
        m.ring = 1'b0;
        for (int i = 0; i < 20 && tone_sb.size() > 0; i++) @(posedge clk);
        #1;
        check("tone_drained", tone_sb.size(), 0);
        hit(1'b0, 3'b000, "hits_low", 1'b0);

        // Reset in the middle of a tone-high phase.
        hit(1'b0, 3'b010, "ring_before_reset", 1'b0);
        repeat (HALF) @(posedge clk);
        #1;
        check("aud_before_reset", aud_pwm, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        sb_q.push_back(m);
        sb_compare("async_reset");
        check("async_reset.aud_pwm", aud_pwm, 1'b0);
        alarm_hit = 3'b000;
        prev_a    = 3'b000;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
